// File: rtl/key_sw_debouncer.sv
// Pushbutton/switch synchronizer and debouncer with an Avalon-MM edge/irq register block.
// Optional SW_EDGE_CAPTURE_EN extends EDGE/MASK capture to the slide switches.
module key_sw_debouncer #(
   parameter int NKEY            = 4,
   parameter int NSW             = 10,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NKEY-1:0] key_in,
   input  logic [NSW-1:0]  sw_in,
   output logic [NKEY-1:0] key_level,
   output logic [NSW-1:0]  sw_level,
   output logic [NKEY-1:0] key_press,
   input  logic [1:0]      avs_address,
   input  logic            avs_read,
   input  logic            avs_write,
   input  logic [31:0]     avs_writedata,
   output logic [31:0]     avs_readdata,
   output logic            irq
);

   localparam int N = NKEY + NSW;
`ifdef SW_EDGE_CAPTURE_EN
   localparam int EW = N;
`else
   localparam int EW = NKEY;
`endif
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NKEY-1:0]  key_s1_q, key_s2_q;
   logic [NSW-1:0]   sw_s1_q, sw_s2_q;
   logic [N-1:0]     sync_v;
   logic [N-1:0]     lvl_q, lvl_d;
   logic [CNT_W-1:0] cnt_q [N];
   logic [CNT_W-1:0] cnt_d [N];
   logic [NKEY-1:0]  press_q;
   logic [EW-1:0]    evt;
   logic [EW-1:0]    edge_q, edge_d;
   logic [EW-1:0]    mask_q, mask_d;
   logic [15:0]      pcnt_q, pcnt_d;
   logic [16:0]      pcnt_sum;
   logic [31:0]      rdata_q, rdata_d;
   logic             irq_q;
   logic             wr_edge, wr_mask, wr_cnt;
   logic             unused_wd;

   // Keys are active-low on the board; invert so everything below is active-high.
   assign sync_v = {sw_s2_q, ~key_s2_q};

   always_comb begin
      lvl_d = lvl_q;
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = '0;
         if (sync_v[i] != lvl_q[i]) begin
            if (cnt_q[i] == CNT_LAST) lvl_d[i] = sync_v[i];
            else cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

`ifdef SW_EDGE_CAPTURE_EN
   logic [NSW-1:0] sw_chg_q;
   always_ff @(posedge clk) begin
      if (reset) sw_chg_q <= '0;
      else sw_chg_q <= lvl_d[N-1:NKEY] ^ lvl_q[N-1:NKEY];
   end
   assign evt = {sw_chg_q, press_q};
`else
   assign evt = press_q;
`endif

   assign wr_edge = avs_write && (avs_address == 2'd1);
   assign wr_mask = avs_write && (avs_address == 2'd2);
   assign wr_cnt  = avs_write && (avs_address == 2'd3);

   // A capture in the same cycle as a W1C wins, so no press is lost.
   always_comb begin
      edge_d = edge_q | evt;
      if (wr_edge) edge_d = (edge_q & ~avs_writedata[EW-1:0]) | evt;
      mask_d = wr_mask ? avs_writedata[EW-1:0] : mask_q;
      pcnt_sum = {1'b0, (wr_cnt ? 16'h0 : pcnt_q)}
               + 17'($countones(press_q));
      pcnt_d = pcnt_sum[16] ? 16'hFFFF : pcnt_sum[15:0];
      unique case (avs_address)
         2'd0: rdata_d = 32'(lvl_q);
         2'd1: rdata_d = 32'(edge_q);
         2'd2: rdata_d = 32'(mask_q);
         2'd3: rdata_d = {16'h0, pcnt_q};
      endcase
   end

   assign unused_wd = ^avs_writedata[31:EW];

   always_ff @(posedge clk) begin
      if (reset) begin
         key_s1_q <= '1;
         key_s2_q <= '1;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         lvl_q    <= '0;
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
         press_q  <= '0;
         edge_q   <= '0;
         mask_q   <= '0;
         pcnt_q   <= '0;
         rdata_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         key_s1_q <= key_in;
         key_s2_q <= key_s1_q;
         sw_s1_q  <= sw_in;
         sw_s2_q  <= sw_s1_q;
         lvl_q    <= lvl_d;
         for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
         press_q  <= lvl_d[NKEY-1:0] & ~lvl_q[NKEY-1:0];
         edge_q   <= edge_d;
         mask_q   <= mask_d;
         pcnt_q   <= pcnt_d;
         if (avs_read) rdata_q <= rdata_d;
         irq_q    <= |(edge_q & mask_q);
      end
   end

   assign key_level    = lvl_q[NKEY-1:0];
   assign sw_level     = lvl_q[N-1:NKEY];
   assign key_press    = press_q;
   assign avs_readdata = rdata_q;
   assign irq          = irq_q;

endmodule

// File: doc/key_sw_debouncer.md
# key_sw_debouncer

Input conditioner between the board pushbuttons/slide switches and the Nios II key PIO path. It synchronizes raw KEY and SW pins and debounces each bit with its own counter. It produces clean levels and one-cycle press pulses. It also exposes an Avalon-MM slave with level, edge-capture and interrupt-mask registers, so firmware can replace raw polling with interrupt-driven input.

## Interface
Parameters:
- NKEY, 4, number of pushbuttons (raw active-low)
- NSW, 10, number of slide switches
- DEBOUNCE_CYCLES, 500000, stable cycles required before a level change is accepted (10 ms at 50 MHz); legal range ≥ 2
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- key_in  in  NKEY  raw KEY pins, active-low, asynchronous
- sw_in  in  NSW  raw SW pins, asynchronous
- key_level  out  NKEY  debounced key state, 1 = pressed
- sw_level  out  NSW  debounced switch state
- key_press  out  NKEY  one-cycle pulse on debounced press
- avs_address  in  2  register word select
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered
- irq  out  1  level interrupt to Nios

## Operation
- Sync: each bit passes through a two-flop synchronizer. Key bits are inverted after sync, so internal logic is active-high.
- Debounce, per bit:
  - If sync value == stable level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the bit still differs, the stable level takes the sync value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
- key_press[i] = 1 for exactly the cycle in which key_level[i] first reads 1. Releases produce no pulse.
- Register map (word addresses):
  - 0 LEVEL (RO): {sw_level, key_level} in bits [NKEY+NSW-1:0]; upper bits 0.
  - 1 EDGE (R/W1C): bit i is set when key_press[i] is high. Writing 1 clears the bit.
  - 2 MASK (RW): interrupt enables for the EDGE bits.
  - 3 PRESSCNT (RO, clear on write): 16-bit saturating count of all key presses, in bits [15:0]. Any write clears it.
- irq = |(EDGE & MASK), driven from registers with no combinational path from the bus.
- Priority: a set and a W1C clear on the same bit in the same cycle leave the bit set. A count increment and a clearing write in the same cycle produce 1.
- Writes to address 0 are ignored. Reads have no side effects.

## Timing
- Reset values:
  - Synchronizer flops: raw-idle, i.e. key 1, sw 0.
  - key_level, sw_level, key_press: 0.
  - EDGE, MASK, PRESSCNT: 0.
  - avs_readdata: 0. irq: 0.
  - All counters: 0.
- Level latency: a raw change held constant from edge 0 makes key_level/sw_level change after edge 1 + DEBOUNCE_CYCLES. key_press is high during that same cycle.
- EDGE bit sets and PRESSCNT increments at the edge following key_press. irq follows one edge after that.
- Read latency is fixed at 1. avs_readdata is valid the cycle after avs_read and holds until the next read. No waitrequest.
- Writes take effect at the edge where avs_write is sampled.
- PRESSCNT saturates at 0xFFFF. Simultaneous presses on several keys add the number of pressed bits, still saturating.
- Reset asserted mid-debounce discards partial counts. After release, levels re-acquire from raw pins, which may produce a key_press if a key is held.

## Configuration
- SW_EDGE_CAPTURE_EN:
  - Defined: EDGE and MASK widen to NKEY+NSW bits. Bits [NKEY+NSW-1:NKEY] capture any debounced sw_level change (both directions), and switch edges can raise irq. Switch edges do not affect PRESSCNT.
  - Undefined: EDGE/MASK bits above NKEY-1 read 0, ignore writes, and are absent from irq.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: pulse reset with key_in=4'hF, sw_in=0 -> all outputs 0, LEVEL read 0x0, irq 0.
- Clean press: key_in[0] goes 1→0 at edge 0 and is held -> key_level[0]=1 and key_press[0] pulse after edge 5 only. EDGE then reads 0x1. PRESSCNT reads 1.
- Glitch: key_in[1] low for 3 cycles, then high -> key_level stays 0, no pulse, EDGE 0.
- IRQ/W1C: MASK=0x1, press key0 -> irq=1. Write EDGE=0x1 -> irq=0 the next cycle. Repeat with a press landing on the clear cycle -> bit stays 1.
- Switch path: sw_in=10'h3FF held -> LEVEL reads 0x3FF0 after edge 5. With SW_EDGE_CAPTURE_EN, EDGE reads 0x3FF0; without it, EDGE reads 0.
- Saturation: 65537 key presses -> PRESSCNT reads 0xFFFF. Write addr 3 -> reads 0.
